traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Single-FSM phase controller for the highway/country intersection. It owns both light outputs and sequences HG → HY → AR → CG → CY → AR → HG. It enforces minimum greens, yellow intervals and an all-red clearance, using one shared internal timer. It replaces the split highway/country pair at the top level, so only one block drives `highway_light` and `country_light`.

## Interface
- `LONG_W`, 7: width of `Timeout` (green durations).
- `SHORT_W`, 4: width of `timeout` (yellow duration, country minimum green).
- `ALLRED_CYC`, 1: all-red clearance length in cycles (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sensor_c`  in  1  country-road vehicle present (synchronous to `clk`).
- `Timeout`  in  LONG_W  highway minimum green and country maximum green, in cycles.
- `timeout`  in  SHORT_W  yellow length and country minimum green, in cycles.
- `highway_light`  out  3  {red, yellow, green}, one-hot.
- `country_light`  out  3  {red, yellow, green}, one-hot.
- `phase`  out  3  current state encoding: HG=0, HY=1, AR1=2, CG=3, CY=4, AR2=5.

## Operation
- Effective durations:
  - L = max(`Timeout`, 1) and S = max(`timeout`, 1).
  - Both are compared live each cycle using ≥, so lowering a value mid-state never hangs the FSM.
- Timer `cnt` (LONG_W bits):
  - Cleared to 0 on every state transition.
  - Increments each cycle otherwise.
  - Saturates at all-ones and never wraps.
- `req` flag:
  - Set in HG on any cycle with `sensor_c`=1.
  - Cleared on the HG→HY transition.
  - Holds a one-cycle sensor pulse seen during HG.
- State transitions (evaluated each rising edge):
  - HG→HY when cnt ≥ L−1 and (`req` or `sensor_c`). Otherwise stays in HG indefinitely.
  - HY→AR1 when cnt ≥ S−1.
  - AR1→CG when cnt ≥ ALLRED_CYC−1.
  - CG→CY when cnt ≥ L−1, or when cnt ≥ S−1 and `sensor_c`=0.
  - CY→AR2 when cnt ≥ S−1.
  - AR2→HG when cnt ≥ ALLRED_CYC−1.
- Light decode (Moore, from the state register only):
  - HG: highway=001, country=100.
  - HY: highway=010, country=100.
  - AR1, AR2: highway=100, country=100.
  - CG: highway=100, country=001.
  - CY: highway=100, country=010.
- Safety invariants:
  - Never both greens; never a green or yellow on both roads at once.
  - Lights are always one-hot per road.
  - Unused `phase` codes 6 and 7 recover to HG on the next edge, with highway=100 and country=100 while in them.

## Timing
- Reset (`reset`=0) asynchronously forces:
  - state=HG, `cnt`=0, `req`=0.
  - `highway_light`=001, `country_light`=100, `phase`=0.
- Reset is effective immediately from any state. It may also be asserted mid-operation, and the effect is identical.
- A state lasting N cycles is visible on the outputs for exactly N rising-edge intervals. New lights appear on the edge where the transition occurs; the outputs have no extra register stage.
- Phase durations with a constant country request:
  - HG = L
  - HY = S
  - AR = ALLRED_CYC
  - CG = L
  - CY = S
- Country early exit: `sensor_c` low on the cycle with cnt = k, with k ≥ S−1, ends CG after k+1 cycles.
- Simultaneous events:
  - A sensor asserted on the HG exit edge is consumed by that transition.
  - A `sensor_c` pulse during HY/AR/CG/CY does not set `req`.

## Test plan
- **Reset values:** assert `reset`=0 mid-CG → outputs 001/100 and `phase`=0 with no clock edge. Release, `sensor_c`=0 for 200 cycles → stays in HG.
- **Full cycle with constant request:** `Timeout`=10, `timeout`=3, `sensor_c`=1 constant → phase durations HG 10, HY 3, AR1 1, CG 10, CY 3, AR2 1, then repeats.
- **Short sensor pulse:** `sensor_c` pulse for 1 cycle at HG cnt=2 → HY entered exactly when cnt reaches 9, i.e. HG lasts 10 cycles.
- **Early country exit:** `sensor_c` high for CG cycles 0–4, low from cnt=5 with `timeout`=3 → CG lasts 6 cycles. If low from cnt=0, CG lasts 3 cycles (minimum green).
- **Zero-duration inputs:** `Timeout`=0, `timeout`=0, `sensor_c`=1 → every phase lasts 1 cycle. Full loop of 6 cycles with no hang and no double green.
- **Live duration change:** in HG at cnt=20, reduce `Timeout` from 50 to 5 with `sensor_c`=1 → HY on the next edge.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// Highway/country intersection phase controller: one FSM, one shared timer,
// sole driver of both light outputs.
module traffic_phase_ctrl #(
  parameter int LONG_W     = 7,
  parameter int SHORT_W    = 4,
  parameter int ALLRED_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_c,
  input  logic [LONG_W-1:0]  Timeout,
  input  logic [SHORT_W-1:0] timeout,
  output logic [2:0]         highway_light,
  output logic [2:0]         country_light,
  output logic [2:0]         phase
);

  localparam logic [2:0] HG  = 3'd0;
  localparam logic [2:0] HY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] CG  = 3'd3;
  localparam logic [2:0] CY  = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [LONG_W-1:0] AR_M1 = LONG_W'(ALLRED_CYC - 1);

  logic [2:0]         state_q, state_d;
  logic [LONG_W-1:0]  cnt_q, cnt_d;
  logic               req_q, req_d;

  // Zero durations are treated as one cycle, so the thresholds are max(x,1)-1.
  logic [LONG_W-1:0]  l_m1;
  logic [SHORT_W-1:0] s_m1_n;
  logic [LONG_W-1:0]  s_m1;

  assign l_m1   = (Timeout == '0) ? '0 : Timeout - 1'b1;
  assign s_m1_n = (timeout == '0) ? '0 : timeout - 1'b1;
  assign s_m1   = LONG_W'(s_m1_n);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HG;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:  if (cnt_q >= l_m1 && (req_q || sensor_c)) state_d = HY;
      HY:  if (cnt_q >= s_m1)                        state_d = AR1;
      AR1: if (cnt_q >= AR_M1)                       state_d = CG;
      CG:  if (cnt_q >= l_m1 || (cnt_q >= s_m1 && !sensor_c)) state_d = CY;
      CY:  if (cnt_q >= s_m1)                        state_d = AR2;
      AR2: if (cnt_q >= AR_M1)                       state_d = HG;
      default:                                       state_d = HG;
    endcase

    // Timer restarts on any state change and sticks at all-ones otherwise.
    if (state_d != state_q)  cnt_d = '0;
    else if (&cnt_q)         cnt_d = cnt_q;
    else                     cnt_d = cnt_q + 1'b1;

    // Request latch only lives in HG; it is consumed by the exit edge.
    if (state_q == HG && state_d == HG) req_d = req_q | sensor_c;
    else                                req_d = 1'b0;
  end

  always_comb begin
    highway_light = RED;
    country_light = RED;
    case (state_q)
      HG:      highway_light = GRN;
      HY:      highway_light = YEL;
      CG:      country_light = GRN;
      CY:      country_light = YEL;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: phase durations, early exit,
// zero durations, live threshold change and async reset.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_c;
  logic [6:0] Timeout;
  logic [3:0] timeout;
  logic [2:0] highway_light, country_light, phase;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

  traffic_phase_ctrl #(.LONG_W(7), .SHORT_W(4), .ALLRED_CYC(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .sensor_c      (sensor_c),
    .Timeout       (Timeout),
    .timeout       (timeout),
    .highway_light (highway_light),
    .country_light (country_light),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Lights one-hot per road and at least one road red, every cycle.
  always @(negedge clk) begin
    chk("safe", int'($onehot(highway_light) && $onehot(country_light) &&
                     (highway_light[2] || country_light[2])), 1);
  end

  task automatic wait_phase(input logic [2:0] p, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (phase == p) break;
      @(negedge clk);
    end
    chk(tag, phase, p);
  endtask

  // Called at the first negedge of phase p; returns at first negedge of the next phase.
  task automatic measure(input logic [2:0] p, input logic [2:0] hl, input logic [2:0] cl,
                         input int exp, input string tag);
    int n;
    chk({tag, "_hl"}, highway_light, hl);
    chk({tag, "_cl"}, country_light, cl);
    n = 0;
    while (phase == p && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, exp);
  endtask

  initial begin
    int n;
    reset = 1'b0; sensor_c = 1'b0; Timeout = 7'd10; timeout = 4'd3;
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_hl", highway_light, G);
    chk("rst_cl", country_light, R);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // No country traffic: HG holds indefinitely.
    repeat (200) @(negedge clk);
    chk("idle_hg", phase, 0);

    // Constant request: full cycle durations.
    sensor_c = 1'b1;
    wait_phase(3'd1, "sync_hy");
    measure(3'd1, Y, R, 3,  "c_hy");
    measure(3'd2, R, R, 1,  "c_ar1");
    measure(3'd3, R, G, 10, "c_cg");
    measure(3'd4, R, Y, 3,  "c_cy");
    measure(3'd5, R, R, 1,  "c_ar2");
    measure(3'd0, G, R, 10, "c_hg");
    measure(3'd1, Y, R, 3,  "c_hy2");

    // Async reset mid-CG, checked between clock edges.
    wait_phase(3'd3, "sync_cg");
    repeat (2) @(negedge clk);
    reset = 1'b0; sensor_c = 1'b0;
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_hl", highway_light, G);
    chk("arst_cl", country_light, R);
    @(negedge clk);
    reset = 1'b1;

    // One-cycle pulse at HG cnt=2 still yields a 10-cycle HG.
    n = 1;
    repeat (2) begin @(negedge clk); n++; end
    sensor_c = 1'b1;
    @(negedge clk); n++;
    sensor_c = 1'b0;
    while (phase == 3'd0 && n < 300) begin n++; @(negedge clk); end
    chk("pulse_hg_len", n - 1, 10);
    measure(3'd1, Y, R, 3, "p_hy");
    sensor_c = 1'b1;
    chk("p_ar1", phase, 2);
    @(negedge clk);

    // Early exit: sensor drops while cnt=5 -> CG lasts 6.
    chk("e_cg_entry", phase, 3);
    n = 0;
    while (phase == 3'd3 && n < 300) begin
      if (n == 5) sensor_c = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("e_cg_len", n, 6);
    measure(3'd4, R, Y, 3, "e_cy");
    measure(3'd5, R, R, 1, "e_ar2");

    // Pulse at HG entry only; CG then sees no sensor and exits at minimum green.
    sensor_c = 1'b1;
    @(negedge clk);
    sensor_c = 1'b0;
    wait_phase(3'd3, "m_sync_cg");
    measure(3'd3, R, G, 3, "m_cg");
    measure(3'd4, R, Y, 3, "m_cy");

    // Zero durations: every phase lasts one cycle.
    wait_phase(3'd0, "z_sync_hg");
    Timeout = 7'd0; timeout = 4'd0; sensor_c = 1'b1;
    wait_phase(3'd1, "z_sync_hy");
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("z_seq%0d", i), phase, (i + 1) % 6);
    end

    // Lowering Timeout mid-HG takes effect on the next edge.
    reset = 1'b0; sensor_c = 1'b0; Timeout = 7'd50; timeout = 4'd3;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("live_pre", phase, 0);
    Timeout = 7'd5; sensor_c = 1'b1;
    @(negedge clk);
    chk("live_hy", phase, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
